// File: rtl/xgmii_link_fault_rs.sv
// xgmii_link_fault_rs
//   Reconciliation-sublayer link fault handler for one 10GBASE-R port.
//   Watches the 64-bit receive XGMII stream for local/remote fault ordered
//   sets, tracks PHY block lock, and keeps a link fault state. The transmit
//   XGMII toward the PHY carries MAC data when the link is OK, remote fault
//   ordered sets while a local fault is present, and idles while a remote
//   fault is present.
//
// Ports:
//   clk           156.25 MHz PHY tx/rx clock (single domain)
//   rst           synchronous active-high reset
//   rx_block_lock PHY receive block lock
//   xgmii_rxd/rxc receive XGMII from PHY (lane 0 at [31:0], lane 4 at [63:32])
//   mac_txd/txc   transmit XGMII from MAC
//   xgmii_txd/txc transmit XGMII to PHY (registered, 1-cycle latency)
//   link_fault    2'b00 OK, 2'b01 local fault, 2'b10 remote fault
//   fault_change  one-cycle pulse whenever link_fault changes value
module xgmii_link_fault_rs #(
    parameter int FAULT_COUNT = 4,
    parameter int WINDOW      = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_block_lock,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic [63:0] mac_txd,
    input  logic [7:0]  mac_txc,
    output logic [63:0] xgmii_txd,
    output logic [7:0]  xgmii_txc,
    output logic [1:0]  link_fault,
    output logic        fault_change
);

    typedef enum logic [1:0] {
        FAULT_OK     = 2'b00,
        FAULT_LOCAL  = 2'b01,
        FAULT_REMOTE = 2'b10
    } fault_t;

    localparam int CW = $clog2(WINDOW + 1);
    // seq_cnt + n can reach FAULT_COUNT + 2 before saturation
    localparam int SW = $clog2(FAULT_COUNT + 3);

    localparam logic [CW-1:0] WIN_C   = CW'(WINDOW);
    localparam logic [CW:0]   WIN_W   = (CW+1)'(WINDOW);
    localparam logic [CW:0]   COL_INC = (CW+1)'(2);
    localparam logic [SW-1:0] FC_C    = SW'(FAULT_COUNT);

    localparam logic [63:0] TXD_RF   = 64'h0200009C_0200009C;
    localparam logic [7:0]  TXC_RF   = 8'h11;
    localparam logic [63:0] TXD_IDLE = 64'h07070707_07070707;
    localparam logic [7:0]  TXC_IDLE = 8'hFF;

    // Fault type carried by one 32-bit half; FAULT_OK means no fault set.
    function automatic fault_t lane_fault(input logic [31:0] d, input logic [3:0] c);
        fault_t t;
        t = FAULT_OK;
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01)
                t = FAULT_LOCAL;
            else if (d[31:24] == 8'h02)
                t = FAULT_REMOTE;
        end
        return t;
    endfunction

    fault_t        fault_q, fault_nxt;
    fault_t        last_type, last_nxt;
    logic [SW-1:0] seq_cnt, seq_nxt;
    logic [CW-1:0] col_cnt, col_nxt;

    fault_t        lo_type, hi_type, set_type;
    logic [1:0]    n_sets;
    logic [SW-1:0] seq_add;
    logic [SW-1:0] seq_new;
    logic [CW:0]   col_sum;
    logic [63:0]   txd_nxt;
    logic [7:0]    txc_nxt;

    always_comb begin
        lo_type  = lane_fault(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
        hi_type  = lane_fault(xgmii_rxd[63:32], xgmii_rxc[7:4]);
        set_type = (hi_type != FAULT_OK) ? hi_type : lo_type;

        // Mixed-type pair: only the upper half counts.
        if (hi_type != FAULT_OK && lo_type != FAULT_OK)
            n_sets = (hi_type == lo_type) ? 2'd2 : 2'd1;
        else if (hi_type != FAULT_OK || lo_type != FAULT_OK)
            n_sets = 2'd1;
        else
            n_sets = 2'd0;

        fault_nxt = fault_q;
        last_nxt  = last_type;
        seq_nxt   = seq_cnt;
        col_nxt   = col_cnt;
        seq_add   = '0;
        seq_new   = '0;
        col_sum   = {1'b0, col_cnt} + COL_INC;

        if (!rx_block_lock) begin
            fault_nxt = FAULT_LOCAL;
            last_nxt  = FAULT_LOCAL;
            seq_nxt   = '0;
            col_nxt   = '0;
        end else if (n_sets != 2'd0) begin
            if (set_type == last_type && col_cnt < WIN_C) begin
                seq_add = seq_cnt + SW'(n_sets);
            end else begin
                seq_add  = SW'(n_sets);
                last_nxt = set_type;
            end
            seq_new = (seq_add >= FC_C) ? FC_C : seq_add;
            seq_nxt = seq_new;
            col_nxt = '0;
            if (seq_new >= FC_C)
                fault_nxt = set_type;
        end else begin
            if (col_sum >= WIN_W) begin
                col_nxt   = WIN_C;
                seq_nxt   = '0;
                fault_nxt = FAULT_OK;
            end else begin
                col_nxt = col_sum[CW-1:0];
            end
        end

        // Transmit selection follows the fault state being registered now.
        case (fault_nxt)
            FAULT_OK: begin
                txd_nxt = mac_txd;
                txc_nxt = mac_txc;
            end
            FAULT_REMOTE: begin
                txd_nxt = TXD_IDLE;
                txc_nxt = TXC_IDLE;
            end
            default: begin
                txd_nxt = TXD_RF;
                txc_nxt = TXC_RF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q      <= FAULT_LOCAL;
            last_type    <= FAULT_LOCAL;
            seq_cnt      <= '0;
            col_cnt      <= '0;
            fault_change <= 1'b0;
            xgmii_txd    <= TXD_RF;
            xgmii_txc    <= TXC_RF;
        end else begin
            fault_q      <= fault_nxt;
            last_type    <= last_nxt;
            seq_cnt      <= seq_nxt;
            col_cnt      <= col_nxt;
            fault_change <= (fault_nxt != fault_q);
            xgmii_txd    <= txd_nxt;
            xgmii_txc    <= txc_nxt;
        end
    end

    assign link_fault = fault_q;

endmodule

// File: tb/tb_xgmii_link_fault_rs.sv
// tb_xgmii_link_fault_rs
//   Directed scenarios followed by randomized receive traffic, every cycle
//   compared against a behavioural model of the link fault rules.
module tb_xgmii_link_fault_rs;

    localparam int FC  = 4;
    localparam int WIN = 128;

    localparam logic [63:0] IDLE_D = 64'h07070707_07070707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] LF_L0  = 64'h07070707_0100009C;
    localparam logic [63:0] RF_L0  = 64'h07070707_0200009C;
    localparam logic [63:0] MIX_D  = 64'h0200009C_0100009C;
    localparam logic [63:0] LF_DBL = 64'h0100009C_0100009C;
    localparam logic [63:0] TX_RF  = 64'h0200009C_0200009C;

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_block_lock;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic [63:0] mac_txd;
    logic [7:0]  mac_txc;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [1:0]  link_fault;
    logic        fault_change;

    int total = 0;
    int bad   = 0;

    // Model state: idle counts whole cycles since the last set / lock loss /
    // reset, run is the unbounded length of the current same-type run.
    int m_fault, m_last, m_run, m_idle, m_chg;

    xgmii_link_fault_rs #(.FAULT_COUNT(FC), .WINDOW(WIN)) dut (
        .clk(clk), .rst(rst), .rx_block_lock(rx_block_lock),
        .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .mac_txd(mac_txd), .mac_txc(mac_txc),
        .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
        .link_fault(link_fault), .fault_change(fault_change)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int half_type(input logic [31:0] d, input logic [3:0] c);
        if (c == 4'b0001 && d[7:0] == 8'h9C && d[15:8] == 8'h00 && d[23:16] == 8'h00) begin
            if (d[31:24] == 8'h01) return 1;
            if (d[31:24] == 8'h02) return 2;
        end
        return 0;
    endfunction

    task automatic model_edge();
        int lo, hi, n, typ, prev;
        if (rst) begin
            m_fault = 1; m_last = 1; m_run = 0; m_idle = 0; m_chg = 0;
            return;
        end
        prev = m_fault;
        lo = half_type(xgmii_rxd[31:0], xgmii_rxc[3:0]);
        hi = half_type(xgmii_rxd[63:32], xgmii_rxc[7:4]);
        if (lo != 0 && hi != 0) n = (lo == hi) ? 2 : 1;
        else n = (lo != 0 ? 1 : 0) + (hi != 0 ? 1 : 0);
        typ = (hi != 0) ? hi : lo;
        if (!rx_block_lock) begin
            m_fault = 1; m_last = 1; m_run = 0; m_idle = 0;
        end else if (n > 0) begin
            if (typ == m_last && 2 * m_idle < WIN) m_run += n;
            else begin m_run = n; m_last = typ; end
            m_idle = 0;
            if (m_run >= FC) m_fault = typ;
        end else begin
            m_idle++;
            if (2 * m_idle >= WIN) m_fault = 0;
        end
        m_chg = (m_fault != prev) ? 1 : 0;
    endtask

    task automatic step(input logic [63:0] d, input logic [7:0] c, input logic lk, input logic r);
        logic [63:0] exp_d;
        logic [7:0]  exp_c;
        xgmii_rxd = d; xgmii_rxc = c; rx_block_lock = lk; rst = r;
        mac_txd = {$urandom, $urandom};
        mac_txc = 8'($urandom);
        @(posedge clk);
        model_edge();
        #1;
        case (m_fault)
            0: begin exp_d = mac_txd; exp_c = mac_txc; end
            2: begin exp_d = IDLE_D;  exp_c = IDLE_C;  end
            default: begin exp_d = TX_RF; exp_c = 8'h11; end
        endcase
        chk("link_fault",   64'(link_fault),   64'(m_fault));
        chk("fault_change", 64'(fault_change), 64'(m_chg));
        chk("xgmii_txd",    xgmii_txd,         exp_d);
        chk("xgmii_txc",    64'(xgmii_txc),    64'(exp_c));
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(IDLE_D, IDLE_C, 1'b1, 1'b0);
    endtask

    function automatic logic [35:0] near_miss();
        case ($urandom_range(0, 3))
            0: return {4'b0001, 32'h0300009C};
            1: return {4'b0001, 32'h0100019C};
            2: return {4'b0011, 32'h0200009C};
            default: return {4'b0000, 32'h0100009C};
        endcase
    endfunction

    // {rxc half, rxd half} chosen with weights depending on traffic mode.
    function automatic logic [35:0] rand_half(input int mode);
        int k;
        k = $urandom_range(0, 99);
        case (mode)
            0: return (k < 95) ? {4'hF, 32'h07070707} : {4'b0001, 32'h0100009C};
            1: begin
                if (k < 50) return {4'b0001, 32'h0100009C};
                if (k < 70) return {4'hF, 32'h07070707};
                if (k < 80) return {4'b0001, 32'h0200009C};
                if (k < 90) return near_miss();
                return {4'($urandom), 32'($urandom)};
            end
            2: begin
                if (k < 50) return {4'b0001, 32'h0200009C};
                if (k < 70) return {4'hF, 32'h07070707};
                if (k < 80) return {4'b0001, 32'h0100009C};
                if (k < 90) return near_miss();
                return {4'($urandom), 32'($urandom)};
            end
            default: begin
                if (k < 30) return {4'hF, 32'h07070707};
                if (k < 55) return {4'b0001, 32'h0100009C};
                if (k < 80) return {4'b0001, 32'h0200009C};
                if (k < 90) return near_miss();
                return {4'($urandom), 32'($urandom)};
            end
        endcase
    endfunction

    initial begin
        int first_ok;
        int seen_local;
        logic [35:0] lo_h, hi_h;

        m_fault = 1; m_last = 1; m_run = 0; m_idle = 0; m_chg = 0;

        // Reset state
        step(IDLE_D, IDLE_C, 1'b1, 1'b1);
        step(IDLE_D, IDLE_C, 1'b1, 1'b1);
        chk("reset_fault", 64'(link_fault), 64'(2'b01));
        chk("reset_txd", xgmii_txd, TX_RF);

        // Reset release: clears after 64 clean cycles
        first_ok = -1;
        for (int i = 1; i <= 70; i++) begin
            step(IDLE_D, IDLE_C, 1'b1, 1'b0);
            if (first_ok < 0 && link_fault == 2'b00) first_ok = i;
        end
        chk("clear_after_reset", 64'(first_ok), 64'(64));

        // Remote fault declare
        for (int k = 0; k < 4; k++) begin
            step(RF_L0, 8'h01, 1'b1, 1'b0);
            if (k < 3) idle(10);
        end
        chk("remote_declare", 64'(link_fault), 64'(2'b10));
        chk("remote_txd", xgmii_txd, IDLE_D);
        idle(70);
        chk("remote_clear", 64'(link_fault), 64'(2'b00));

        // Window break restarts the run
        for (int k = 0; k < 3; k++) begin
            step(LF_L0, 8'h01, 1'b1, 1'b0);
            idle(10);
        end
        idle(60);
        step(LF_L0, 8'h01, 1'b1, 1'b0);
        chk("window_break", 64'(link_fault), 64'(2'b00));
        for (int k = 0; k < 3; k++) begin
            idle(10);
            step(LF_L0, 8'h01, 1'b1, 1'b0);
        end
        chk("restart_run", 64'(link_fault), 64'(2'b01));
        idle(70);

        // Type switch via a mixed-type cycle
        seen_local = 0;
        for (int k = 0; k < 3; k++) begin
            step(LF_L0, 8'h01, 1'b1, 1'b0);
            if (link_fault == 2'b01) seen_local = 1;
            idle(2);
        end
        step(MIX_D, 8'h11, 1'b1, 1'b0);
        if (link_fault == 2'b01) seen_local = 1;
        for (int k = 0; k < 3; k++) begin
            idle(2);
            step(RF_L0, 8'h01, 1'b1, 1'b0);
            if (link_fault == 2'b01) seen_local = 1;
        end
        chk("type_switch", 64'(link_fault), 64'(2'b10));
        chk("never_local", 64'(seen_local), 64'(0));
        idle(70);

        // Fastest declaration: two double-set cycles
        step(LF_DBL, 8'h11, 1'b1, 1'b0);
        chk("double_first", 64'(link_fault), 64'(2'b00));
        step(LF_DBL, 8'h11, 1'b1, 1'b0);
        chk("double_second", 64'(link_fault), 64'(2'b01));
        chk("double_change", 64'(fault_change), 64'(1));
        idle(70);

        // Lock loss for one cycle
        step(IDLE_D, IDLE_C, 1'b0, 1'b0);
        chk("lock_loss", 64'(link_fault), 64'(2'b01));
        first_ok = -1;
        for (int i = 1; i <= 70; i++) begin
            step(IDLE_D, IDLE_C, 1'b1, 1'b0);
            if (first_ok < 0 && link_fault == 2'b00) first_ok = i;
        end
        chk("clear_after_lock", 64'(first_ok), 64'(64));

        // Mid-run reset
        for (int k = 0; k < 4; k++) step(RF_L0, 8'h01, 1'b1, 1'b0);
        chk("pre_reset_remote", 64'(link_fault), 64'(2'b10));
        step(RF_L0, 8'h01, 1'b1, 1'b1);
        chk("midrun_reset_fault", 64'(link_fault), 64'(2'b01));
        chk("midrun_reset_txd", xgmii_txd, TX_RF);
        chk("midrun_reset_txc", 64'(xgmii_txc), 64'(8'h11));

        // Randomized traffic
        for (int seg = 0; seg < 15; seg++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 200; i++) begin
                lo_h = rand_half(mode);
                hi_h = rand_half(mode);
                step({hi_h[31:0], lo_h[31:0]}, {hi_h[35:32], lo_h[35:32]},
                     ($urandom_range(0, 199) != 0), ($urandom_range(0, 999) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xgmii_link_fault_rs.md
# xgmii_link_fault_rs

Reconciliation-sublayer link fault handler for one 10GBASE-R port, sitting between the `fpga_core` MAC datapath and the `eth_xcvr_phy_wrapper` XGMII ports. It watches the PHY's 64-bit receive XGMII stream for local/remote fault ordered sets and tracks the PHY block lock to maintain a link fault state. It then drives the transmit XGMII toward the PHY:

- passes MAC data through when the link is OK;
- sends remote fault ordered sets while a local fault is present;
- sends idles while a remote fault is present.

## Interface

Parameters:
- `FAULT_COUNT`, default 4: number of same-type fault ordered sets, each within `WINDOW` columns of the previous, needed to declare a fault.
- `WINDOW`, default 128: number of fault-free XGMII columns that clears a fault or breaks a sequence run. Must be even; 2 columns per cycle.

Ports:
- `clk`, input, 1: 156.25 MHz PHY tx/rx clock (single domain).
- `rst`, input, 1: reset, synchronous and active-high.
- `rx_block_lock`, input, 1: PHY receive block lock.
- `xgmii_rxd`, input, 64: receive data from PHY.
- `xgmii_rxc`, input, 8: receive control from PHY.
- `mac_txd`, input, 64: transmit data from MAC.
- `mac_txc`, input, 8: transmit control from MAC.
- `xgmii_txd`, output, 64: transmit data to PHY.
- `xgmii_txc`, output, 8: transmit control to PHY.
- `link_fault`, output, 2: 2'b00 OK, 2'b01 local fault, 2'b10 remote fault (2'b11 never driven).
- `fault_change`, output, 1: one-cycle pulse whenever `link_fault` changes value.

## Operation

Ordered set detection per 32-bit half: lane 0 at [31:0], lane 4 at [63:32].
- A half holds a fault ordered set when all of these hold: rxc bits = 4'b0001, byte0 = 8'h9C, byte1 = 8'h00, byte2 = 8'h00, byte3 ∈ {8'h01 local, 8'h02 remote}.
- Any other byte3 value is not a fault ordered set.
- `n` = number of halves holding a set this cycle (0–2). `type` = type of the upper half if it holds a set, else the lower half.
- If both halves hold sets of different types, only the upper half counts and `n` is 1.

Counters and state:
- `col_cnt` saturates at `WINDOW`.
- `seq_cnt` saturates at `FAULT_COUNT`.
- `last_type` holds the type of the most recent counted set.

Per-cycle update (first matching rule wins):
- **`rx_block_lock` = 0**: `link_fault` ← local. `seq_cnt` ← 0, `col_cnt` ← 0, `last_type` ← local.
- **`n` > 0**:
  - If `type == last_type` and `col_cnt < WINDOW`: `seq_cnt` ← `seq_cnt + n`.
  - Otherwise: `seq_cnt` ← `n` and `last_type` ← `type`.
  - `col_cnt` ← 0.
  - If the new `seq_cnt ≥ FAULT_COUNT`: `link_fault` ← `type`.
- **`n` = 0**: `col_cnt` ← `col_cnt + 2`. When the new value reaches `WINDOW`: `link_fault` ← OK and `seq_cnt` ← 0.

Transmit mux, selected by the `link_fault` value registered in the same cycle (its new value):
- OK: `xgmii_txd`/`xgmii_txc` = `mac_txd`/`mac_txc`.
- Local: remote fault sets in both lanes, `xgmii_txd` = 64'h0200009C_0200009C, `xgmii_txc` = 8'h11.
- Remote: idles, `xgmii_txd` = 64'h07070707_07070707, `xgmii_txc` = 8'hFF.

Override takes effect mid-frame with no frame-boundary wait. Frame truncation is accepted; the MAC sees no back-pressure.

## Timing

- Reset values: `link_fault` = 2'b01 (local), `xgmii_txd` = 64'h0200009C_0200009C, `xgmii_txc` = 8'h11, `fault_change` = 0, `seq_cnt` = 0, `col_cnt` = 0, `last_type` = local.
- Status latency: 1 cycle. `link_fault` updates at the edge after the qualifying `xgmii_rxd` cycle, with `fault_change` high in that same cycle.
- Datapath latency: 1 cycle. `xgmii_txd` at edge k+1 reflects `mac_txd` at edge k when OK.
- When `link_fault` changes at edge k+1, the `xgmii_txd` driven at edge k+1 already uses the new selection.
- Clearing a fault from a clean stream takes `WINDOW`/2 = 64 fault-free cycles after the last set or lock recovery.
- A fault is declared no earlier than 2 cycles with `FAULT_COUNT` = 4 (two double-set cycles).
- Reset asserted mid-operation: all state returns to reset values on the next edge regardless of inputs.

## Test plan

- **Reset release:** lock = 1, idle rx. Required: `link_fault` = 01 and tx = remote fault sets for 64 cycles; then `link_fault` = 00 with a `fault_change` pulse; tx then follows `mac_txd` with 1-cycle latency.
- **Remote fault declare:** from OK, send 4 cycles with lane 0 only = 0x0200009C (rxc 8'h01), separated by 10 idle cycles. Required: `link_fault` = 10 one cycle after the 4th; tx = 64'h0707…07 / 8'hFF.
- **Window break:** 3 local sets spaced 10 cycles apart, then 70 idle cycles, then 1 local set. Required: `link_fault` stays 00 (run restarted, `seq_cnt` = 1).
- **Type switch:** 3 local sets, then one cycle with lane 0 local and lane 4 remote, then 3 remote sets. Required: fault = 10 after the 3rd remote set (count 1+3), never 01.
- **Lock loss:** while OK, drop `rx_block_lock` for 1 cycle. Required: `link_fault` = 01 next cycle; clears to 00 exactly 64 idle cycles after lock returns.
- **Mid-run reset:** `link_fault` = 10 with `seq_cnt` = 4, assert `rst` for 1 cycle. Required: next edge `link_fault` = 01, tx = 64'h0200009C_0200009C / 8'h11.
